// File: rtl/ex_ctrl_skid_register.sv
// Two-entry skid buffer carrying the EX control bundle (ALUSrc, ALUOp, RegDst) across ID/EX.
// Optional saturating stall counter is enabled by defining EX_SKID_STALL_CNT_EN.
module ex_ctrl_skid_register #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_Valid,
  output logic               in_Ready,
  input  logic               in_ALUSrc,
  input  logic [ALUOP_W-1:0] in_ALUOp,
  input  logic               in_RegDst,
  input  logic               Flush,
  output logic               out_Valid,
  input  logic               out_Ready,
  output logic               out_ALUSrc,
  output logic [ALUOP_W-1:0] out_ALUOp,
  output logic               out_RegDst
`ifdef EX_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  localparam int PW = ALUOP_W + 2;

  // A counter narrower than two bits cannot hold the increment constant below.
  if (CNT_W < 2) begin : g_cnt_w_too_small
  end

  logic          m_valid_r;
  logic          s_valid_r;
  logic [PW-1:0] m_bundle_r;
  logic [PW-1:0] s_bundle_r;
  logic [PW-1:0] in_bundle_s;
  logic          accept_s;
  logic          drain_s;

  assign in_bundle_s = {in_ALUSrc, in_ALUOp, in_RegDst};
  assign accept_s    = in_Valid & ~s_valid_r;
  assign drain_s     = m_valid_r & out_Ready;

  // Both handshake outputs come straight from flops, so out_Ready never reaches in_Ready.
  assign in_Ready  = ~s_valid_r;
  assign out_Valid = m_valid_r;
  assign {out_ALUSrc, out_ALUOp, out_RegDst} = m_bundle_r;

  // Slot state: reset beats flush beats normal handshaking.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      m_bundle_r <= {PW{1'b0}};
      s_bundle_r <= {PW{1'b0}};
    end else if (Flush) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
    end else if (!m_valid_r || drain_s) begin
      // Main is free this edge; the skid entry is older than anything arriving now.
      if (s_valid_r) begin
        m_bundle_r <= s_bundle_r;
        m_valid_r  <= 1'b1;
        s_valid_r  <= 1'b0;
      end else if (accept_s) begin
        m_bundle_r <= in_bundle_s;
        m_valid_r  <= 1'b1;
      end else begin
        m_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      s_bundle_r <= in_bundle_s;
      s_valid_r  <= 1'b1;
    end else begin
      s_valid_r <= s_valid_r;
    end
  end

`ifdef EX_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Counts stalled-output cycles, saturating; only reset clears it, flush leaves it alone.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (m_valid_r && !out_Ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_ex_ctrl_skid_register.sv
// Bench for ex_ctrl_skid_register: directed handshake scenarios plus a randomized run,
// all observed by a scoreboard that models the block as a depth-2 FIFO.
module tb_ex_ctrl_skid_register;

  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;

  logic               Clk;
  logic               Rst;
  logic               in_Valid;
  logic               in_Ready;
  logic               in_ALUSrc;
  logic [ALUOP_W-1:0] in_ALUOp;
  logic               in_RegDst;
  logic               Flush;
  logic               out_Valid;
  logic               out_Ready;
  logic               out_ALUSrc;
  logic [ALUOP_W-1:0] out_ALUOp;
  logic               out_RegDst;
`ifdef EX_SKID_STALL_CNT_EN
  logic [CNT_W-1:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [ALUOP_W+1:0] exp_q[$];

  ex_ctrl_skid_register #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_Valid   (in_Valid),
    .in_Ready   (in_Ready),
    .in_ALUSrc  (in_ALUSrc),
    .in_ALUOp   (in_ALUOp),
    .in_RegDst  (in_RegDst),
    .Flush      (Flush),
    .out_Valid  (out_Valid),
    .out_Ready  (out_Ready),
    .out_ALUSrc (out_ALUSrc),
    .out_ALUOp  (out_ALUOp),
    .out_RegDst (out_RegDst)
`ifdef EX_SKID_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, then returns at the falling edge.
  task automatic drive(input logic v, input logic src, input logic [ALUOP_W-1:0] op,
                       input logic dst, input logic ordy, input logic fl, input logic rst);
    @(posedge Clk);
    #1;
    in_Valid  = v;
    in_ALUSrc = src;
    in_ALUOp  = op;
    in_RegDst = dst;
    out_Ready = ordy;
    Flush     = fl;
    Rst       = rst;
    @(negedge Clk);
  endtask

  task automatic cyc(input logic v, input logic [ALUOP_W-1:0] op, input logic ordy,
                     input logic fl, input logic rst = 1'b1);
    drive(v, op[0], op, op[1], ordy, fl, rst);
  endtask

  // Scoreboard: compares the DUT against a depth-2 FIFO, then applies this cycle's handshakes.
  always @(negedge Clk) begin
    int n;
    n = exp_q.size();
    if (!Rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready", 32'(in_Ready), 32'(n < 2));
      chk("out_valid", 32'(out_Valid), 32'(n > 0));
      if (n > 0) chk("out_bundle", 32'({out_ALUSrc, out_ALUOp, out_RegDst}), 32'(exp_q[0]));
      if (Flush) begin
        exp_q.delete();
      end else begin
        if (out_Ready && n > 0) void'(exp_q.pop_front());
        if (in_Valid && n < 2) exp_q.push_back({in_ALUSrc, in_ALUOp, in_RegDst});
      end
    end
  end

  initial begin
    Rst = 1'b0; in_Valid = 1'b1; in_ALUSrc = 1'b1; in_ALUOp = 4'd9; in_RegDst = 1'b1;
    Flush = 1'b0; out_Ready = 1'b0;

    // Reset held for two edges with input offered.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_out_valid", 32'(out_Valid), 32'd0);
    chk("rst_out_aluop", 32'(out_ALUOp), 32'd0);
    chk("rst_out_alusrc", 32'(out_ALUSrc), 32'd0);
    chk("rst_in_ready", 32'(in_Ready), 32'd1);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    chk("rst_release_valid", 32'(out_Valid), 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("first_latency_valid", 32'(out_Valid), 32'd1);
    chk("first_latency_aluop", 32'(out_ALUOp), 32'd3);

    // Streaming 1..4 with EX always ready.
    for (int i = 1; i <= 5; i++) begin
      cyc(i <= 4, 4'(i), 1'b1, 1'b0);
      chk("stream_in_ready", 32'(in_Ready), 32'd1);
      if (i >= 2) begin
        chk("stream_valid", 32'(out_Valid), 32'd1);
        chk("stream_aluop", 32'(out_ALUOp), 32'(i - 1));
      end
    end
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("stream_end_valid", 32'(out_Valid), 32'd0);

    // Backpressure: 5 in main, 6 in skid, then release.
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    chk("bp_one_held_aluop", 32'(out_ALUOp), 32'd5);
    chk("bp_one_held_ready", 32'(in_Ready), 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("bp_full_ready", 32'(in_Ready), 32'd0);
    chk("bp_full_aluop", 32'(out_ALUOp), 32'd5);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("bp_hold_aluop", 32'(out_ALUOp), 32'd5);
    chk("bp_hold_valid", 32'(out_Valid), 32'd1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("bp_release_aluop", 32'(out_ALUOp), 32'd5);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("bp_second_aluop", 32'(out_ALUOp), 32'd6);
    chk("bp_second_ready", 32'(in_Ready), 32'd1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("bp_empty_valid", 32'(out_Valid), 32'd0);
    chk("bp_empty_ready", 32'(in_Ready), 32'd1);

    // Flush with both slots full, then flush racing an accept into a half-full buffer.
    cyc(1'b1, 4'd10, 1'b0, 1'b0);
    cyc(1'b1, 4'd11, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 1'b0, 1'b1);
    chk("flush_full_ready", 32'(in_Ready), 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("flush_valid", 32'(out_Valid), 32'd0);
    chk("flush_ready", 32'(in_Ready), 32'd1);
    cyc(1'b1, 4'd12, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 1'b0, 1'b1);
    chk("flush_accept_ready", 32'(in_Ready), 32'd1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("flush_accept_valid", 32'(out_Valid), 32'd0);
    repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 999) != 0);
    end

    // Reset mid-operation zeroes the payload.
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("pre_rst_aluop", 32'(out_ALUOp), 32'hA);
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("mid_rst_valid", 32'(out_Valid), 32'd0);
    chk("mid_rst_aluop", 32'(out_ALUOp), 32'd0);
    chk("mid_rst_in_ready", 32'(in_Ready), 32'd1);

`ifdef EX_SKID_STALL_CNT_EN
    chk("cnt_reset", 32'(stall_cnt), 32'd0);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    repeat (11) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("cnt_ten", 32'(stall_cnt), 32'd10);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("cnt_before_flush", 32'(stall_cnt), 32'd11);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("cnt_after_flush", 32'(stall_cnt), 32'd11);
    chk("cnt_flush_valid", 32'(out_Valid), 32'd0);
`endif

    repeat (2) cyc(1'b0, 4'd0, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
